decoder_3to8_buf: RTL and testbench
===================================

DECODER_3TO8_BUF -- requirements
Module: decoder_3to8_buf

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  producer presents a code this cycle.
REQ-005 in_code  input  3  binary index 0..7 to decode.
REQ-006 in_ready  output  1  block can accept a code this cycle.
REQ-007 out_valid  output  1  out_onehot holds a decoded entry.
REQ-008 out_onehot  output  8  one-hot decode of head entry: bit in_code set, all others clear.
REQ-009 out_ready  input  1  consumer takes the head entry this cycle.
REQ-010 level  output  2  FIFO occupancy, 0..2.

Function
REQ-011 SHALL accept (push) a code on a rising clk edge when in_valid=1 and in_ready=1.
REQ-012 SHALL pop the head entry on a rising clk edge when out_valid=1 and out_ready=1.
REQ-013 SHALL store each accepted code in a 2-entry FIFO, decoded to one-hot at push time: entry = 8'b1 << in_code.
REQ-014 SHALL drive in_ready = (level != 2), combinationally from registered level only, with no dependence on out_ready.
REQ-015 SHALL drive out_valid = (level != 0), combinationally from registered level only.
REQ-016 SHALL drive out_onehot from the head entry register when out_valid=1, with no combinational path from in_code.
REQ-017 Latency: a code accepted at edge N into an empty FIFO SHALL appear on out_valid/out_onehot immediately after edge N.
REQ-018 Ordering: entries SHALL pop in strict push order.
REQ-019 Simultaneous push and pop at level 1 SHALL leave level at 1 and make the new entry the head after the edge.
REQ-020 Simultaneous push and pop at level 0 SHALL NOT occur, because out_valid=0; the push alone SHALL take effect.
REQ-021 At level 2, in_ready SHALL be 0. A pop alone SHALL take level to 1, and in_ready SHALL return to 1 after that edge.
REQ-022 in_valid=1 with in_ready=0 SHALL NOT alter state; the producer holds in_code until it is accepted.
REQ-023 Exactly one bit of out_onehot SHALL be set whenever out_valid=1.
REQ-024 level SHALL equal pushes minus pops since reset, and SHALL never wrap.

Reset
REQ-025 rst_n=0 SHALL immediately clear both FIFO entries, the read and write pointers, and level, independent of clk.
REQ-026 During reset, outputs SHALL be in_ready=1, out_valid=0, out_onehot=8'h00 and level=0.
REQ-027 Reset asserted mid-transfer SHALL discard all stored entries.
REQ-028 After rst_n deasserts, the first push SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-029 The macro DEC_HOLD_EN SHALL select how out_onehot behaves when out_valid=0.
REQ-030 With DEC_HOLD_EN defined: when out_valid=0, out_onehot SHALL hold the most recently popped entry, or 8'h00 if nothing has been popped since reset.
REQ-031 Without DEC_HOLD_EN: when out_valid=0, out_onehot SHALL be 8'h00.
REQ-032 The macro SHALL NOT affect handshake timing or level in either setting.

Verification
REQ-033 Reset mid-run: with level=2, pulse rst_n low between edges -> level=0, out_valid=0, out_onehot=8'h00 and in_ready=1 without a clk edge.
REQ-034 Single decode: push codes 0..7 with out_ready=1 throughout -> out_onehot sequence 01,02,04,08,10,20,40,80, each valid one cycle after its push.
REQ-035 Fill and stall: out_ready=0, push 3 then 5 -> level=2 and in_ready=0. A third code 7, held with in_valid=1, is not accepted. Set out_ready=1 -> outputs 08, then 20, then 80.
REQ-036 Simultaneous push/pop: level=1 with head=01, push 6 and pop on the same edge -> level stays 1 and out_onehot=40.
REQ-037 Idle output, both builds: push 2, pop it, then idle -> out_onehot=8'h04 with DEC_HOLD_EN defined, 8'h00 without it.
REQ-038 Random traffic: random in_valid/out_ready over 10k cycles against a reference queue -> order preserved, exactly one bit set whenever out_valid=1, level always within 0..2.

Source files
------------

// File: rtl/decoder_3to8_buf.sv
// 3-to-8 one-hot decoder feeding a 2-entry valid/ready FIFO; codes are decoded at push time.
// Optional build macro DEC_HOLD_EN: when defined, the idle output holds the last popped entry.
module decoder_3to8_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_onehot,
    input  logic       out_ready,
    output logic [1:0] level
);

    function automatic logic [7:0] decode_code(input logic [2:0] code);
        decode_code = 8'h01 << code;
    endfunction

    logic [7:0] entry_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] level_r;
    logic       push_s;
    logic       pop_s;
    logic [7:0] idle_value_s;
    logic [7:0] out_onehot_s;

    // Handshake status depends only on registered occupancy
    assign in_ready  = (level_r != 2'd2);
    assign out_valid = (level_r != 2'd0);
    assign level     = level_r;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r[0] <= 8'h00;
            entry_r[1] <= 8'h00;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            level_r    <= 2'd0;
        end else begin
            if (push_s) begin
                entry_r[wr_ptr_r] <= decode_code(in_code);
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 2'd1;
                2'b01:   level_r <= level_r - 2'd1;
                default: level_r <= level_r;
            endcase
        end
    end

`ifdef DEC_HOLD_EN
    logic [7:0] last_pop_r;

    // Remember the entry most recently handed to the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pop_r <= 8'h00;
        end else if (pop_s) begin
            last_pop_r <= entry_r[rd_ptr_r];
        end else begin
            last_pop_r <= last_pop_r;
        end
    end

    assign idle_value_s = last_pop_r;
`else
    assign idle_value_s = 8'h00;
`endif

    // Output mux draws only from registers, never from in_code
    always_comb begin
        out_onehot_s = 8'h00;
        if (out_valid) begin
            out_onehot_s = entry_r[rd_ptr_r];
        end else begin
            out_onehot_s = idle_value_s;
        end
    end

    assign out_onehot = out_onehot_s;

endmodule

// File: tb/tb_decoder_3to8_buf.sv
// Self-checking bench for decoder_3to8_buf against a queue-based reference model.
module tb_decoder_3to8_buf;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic       out_ready;
    logic [1:0] level;

    int vectors;
    int miscompares;

    logic [7:0] ref_q[$];
    logic [7:0] ref_last;

`ifdef DEC_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    decoder_3to8_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: expected idle/head value from the queue
    function automatic logic [7:0] ref_out();
        if (ref_q.size() != 0) return ref_q[0];
        if (HOLD) return ref_last;
        return 8'h00;
    endfunction

    // Advance one clock: model applies handshake rules at the edge, then return to negedge
    task automatic step();
        bit acc;
        bit pop;
        @(posedge clk);
        acc = in_valid && (ref_q.size() < 2);
        pop = out_ready && (ref_q.size() > 0);
        if (pop) ref_last = ref_q.pop_front();
        if (acc) ref_q.push_back(8'h01 << in_code);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ref_q.delete();
        ref_last = 8'h00;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_code = 3'd0; out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== 8'h00 || level !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b oh=%h lvl=%0d, required 1 0 00 0", in_ready, out_valid, out_onehot, level);
        end
        ref_q.delete(); ref_last = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_decode();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_code = 3'(i);
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_onehot !== (8'h01 << i)) begin
                miscompares++;
                $display("FAIL single_decode code %0d: vld=%b oh=%h, required 1 %h", i, out_valid, out_onehot, 8'h01 << i);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_decode drain: lvl=%0d vld=%b, required 0 0", level, out_valid);
        end
    endtask

    task automatic test_fill_stall();
        logic [7:0] expv [3];
        expv[0] = 8'h08; expv[1] = 8'h20; expv[2] = 8'h80;
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd3; step();
        in_code = 3'd5; step();
        vectors++;
        if (level !== 2'd2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill: lvl=%0d rdy=%b, required 2 0", level, in_ready);
        end
        in_code = 3'd7; step();
        vectors++;
        if (level !== 2'd2 || out_onehot !== 8'h08) begin
            miscompares++;
            $display("FAIL stall: lvl=%0d oh=%h, required 2 08", level, out_onehot);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_onehot !== expv[i]) begin
                miscompares++;
                $display("FAIL drain_order %0d: vld=%b oh=%h, required 1 %h", i, out_valid, out_onehot, expv[i]);
            end
            step();
            if (i == 1) in_valid = 1'b0;
        end
        vectors++;
        if (level !== 2'd0) begin
            miscompares++;
            $display("FAIL fill_final_level: lvl=%0d, required 0", level);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd0; step();
        vectors++;
        if (level !== 2'd1 || out_onehot !== 8'h01) begin
            miscompares++;
            $display("FAIL simul_setup: lvl=%0d oh=%h, required 1 01", level, out_onehot);
        end
        out_ready = 1'b1; in_code = 3'd6; step();
        vectors++;
        if (level !== 2'd1 || out_onehot !== 8'h40) begin
            miscompares++;
            $display("FAIL simul_push_pop: lvl=%0d oh=%h, required 1 40", level, out_onehot);
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_idle();
        logic [7:0] want;
        want = HOLD ? 8'h04 : 8'h00;
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd2; step();
        in_valid = 1'b0; out_ready = 1'b1; step();
        out_ready = 1'b0; step(); step();
        vectors++;
        if (out_valid !== 1'b0 || out_onehot !== want) begin
            miscompares++;
            $display("FAIL idle_output: vld=%b oh=%h, required 0 %h", out_valid, out_onehot, want);
        end
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd1; step();
        in_code = 3'd4; step();
        in_valid = 1'b0;
        vectors++;
        if (level !== 2'd2) begin
            miscompares++;
            $display("FAIL midrun_fill: lvl=%0d, required 2", level);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_onehot !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_reset: lvl=%0d vld=%b oh=%h rdy=%b, required 0 0 00 1", level, out_valid, out_onehot, in_ready);
        end
        ref_q.delete(); ref_last = 8'h00;
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1; step();
        vectors++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin
            miscompares++;
            $display("FAIL midrun_discard: vld=%b oh=%h, required 0 00", out_valid, out_onehot);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            // Producer holds its code while stalled
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_code  = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            vectors++;
            if (level !== 2'(ref_q.size()) || out_valid !== (ref_q.size() != 0) ||
                in_ready !== (ref_q.size() != 2) || out_onehot !== ref_out() ||
                (out_valid && $countones(out_onehot) != 1)) begin
                miscompares++;
                if (errs < 10)
                    $display("FAIL random cycle %0d: lvl=%0d vld=%b rdy=%b oh=%h, required %0d %b %b %h",
                             c, level, out_valid, in_ready, out_onehot,
                             ref_q.size(), ref_q.size() != 0, ref_q.size() != 2, ref_out());
                errs++;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        ref_last = 8'h00;
        test_reset();
        test_single_decode();
        test_fill_stall();
        test_simultaneous();
        test_idle();
        test_reset_midrun();
        do_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
